// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: write-port controller for the 32x32 register file.
// Arbitrates the single write port between writeback (WB) and an auxiliary
// requester, which is buffered in a small FIFO. A pending-write scoreboard
// raises a decode read-hazard stall.
//
// Optional feature macro: REGFILE_STARVE_GUARD_EN
// (forces the aux head through after StarveLimit lost cycles).
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   wb_valid_i/addr_i/data_i writeback write request
//   wb_ready_o               writeback write accepted this cycle
//   aux_valid_i/addr_i/data_i auxiliary write request
//   aux_ready_o              aux FIFO not full
//   rs1_addr_i, rs2_addr_i   decode-stage source registers
//   rd_stall_o               a source register has a write pending/in flight
//   rf_wr_en_o/addr_o/data_o registered register-file write port
module regfile_wr_ctrl #(
  parameter int unsigned AuxDepth    = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ready_o,
  input  logic        aux_valid_i,
  input  logic [4:0]  aux_addr_i,
  input  logic [31:0] aux_data_i,
  output logic        aux_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        rd_stall_o,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o
);

  localparam int unsigned PtrW = (AuxDepth > 1) ? $clog2(AuxDepth) : 1;
  localparam int unsigned CntW = $clog2(AuxDepth + 1);

  logic [4:0]      fifo_addr_q [AuxDepth];
  logic [31:0]     fifo_data_q [AuxDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] slot_off;
  logic [AuxDepth-1:0] entry_vld;
  logic [31:0]     pending;
  logic            fifo_empty, push, pop, grant_wb, wb_hit, starve_fire;
  logic            rs1_hit, rs2_hit;

  logic            rf_wr_en_q, rf_wr_en_d;
  logic [4:0]      rf_wr_addr_q, rf_wr_addr_d;
  logic [31:0]     rf_wr_data_q, rf_wr_data_d;

  assign fifo_empty  = (count_q == '0);
  assign aux_ready_o = (count_q != CntW'(AuxDepth));
  // x0 writes are acknowledged but never enter the FIFO.
  assign push        = aux_valid_i && aux_ready_o && (aux_addr_i != '0);

  // Scoreboard: valid slots are those within count_q of the read pointer.
  always_comb begin
    entry_vld = '0;
    pending   = '0;
    wb_hit    = 1'b0;
    slot_off  = '0;
    for (int unsigned i = 0; i < AuxDepth; i++) begin
      slot_off     = PtrW'(i) - rd_ptr_q;
      entry_vld[i] = (CntW'(slot_off) < count_q);
      if (entry_vld[i]) begin
        pending[fifo_addr_q[i]] = 1'b1;
        if (wb_valid_i && (wb_addr_i == fifo_addr_q[i])) wb_hit = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef REGFILE_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(StarveLimit + 1);
  logic [StW-1:0] starve_q, starve_d;

  assign starve_fire = (starve_q == StW'(StarveLimit));

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (grant_wb && !starve_fire) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  // StarveLimit only matters with the guard enabled.
  logic unused_starve_limit;
  assign unused_starve_limit = ^StarveLimit;
  assign starve_fire         = 1'b0;
`endif

  // Grant: an older aux write to the same register must land first.
  always_comb begin
    wb_ready_o = 1'b1;
    grant_wb   = 1'b0;
    pop        = 1'b0;
    if (fifo_empty) begin
      grant_wb = wb_valid_i;
    end else if (wb_hit || starve_fire) begin
      pop        = 1'b1;
      wb_ready_o = 1'b0;
    end else if (wb_valid_i) begin
      grant_wb = 1'b1;
    end else begin
      pop = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (grant_wb && (wb_addr_i != '0)) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = wb_addr_i;
      rf_wr_data_d = wb_data_i;
    end else if (pop) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = fifo_addr_q[rd_ptr_q];
      rf_wr_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      for (int i = 0; i < int'(AuxDepth); i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= aux_addr_i;
        fifo_data_q[wr_ptr_q] <= aux_data_i;
      end
    end
  end

  // Stall on a queued write or the write currently on the rf port.
  assign rs1_hit = (rs1_addr_i != '0) &&
                   (pending[rs1_addr_i] || (rf_wr_en_q && (rf_wr_addr_q == rs1_addr_i)));
  assign rs2_hit = (rs2_addr_i != '0) &&
                   (pending[rs2_addr_i] || (rf_wr_en_q && (rf_wr_addr_q == rs2_addr_i)));
  assign rd_stall_o = rs1_hit || rs2_hit;

  assign rf_wr_en_o   = rf_wr_en_q;
  assign rf_wr_addr_o = rf_wr_addr_q;
  assign rf_wr_data_o = rf_wr_data_q;

endmodule
